// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring_reader read side of the 4-entry word store.
package ring_pkg;

    localparam int RING_DEPTH = 4;
    localparam int RING_WIDTH = 32;
    localparam int RING_PTR_W = 2;

    // Phase tag attached to every stored word.
    typedef enum logic [1:0] {
        PASS = 2'd0,
        HALF = 2'd1,
        SHR  = 2'd2,
        ZERO = 2'd3
    } phase_e;

    // Reader control states.
    typedef enum logic {
        ST_WAIT    = 1'b0,
        ST_PRESENT = 1'b1
    } rd_state_e;

    // Map the writer's cycle counter onto its phase tag.
    function automatic phase_e classify_phase(input logic [7:0] cnt);
        phase_e ph;
        if (cnt == 8'h00) begin
            ph = PASS;
        end else if (cnt < 8'h80) begin
            ph = HALF;
        end else if (cnt < 8'hC0) begin
            ph = SHR;
        end else begin
            ph = ZERO;
        end
        return ph;
    endfunction

endpackage

// File: rtl/ring_slot_bank.sv
// Four tagged word slots: write port, per-slot valid bits, clear-on-load
// and detection of a write landing on a still-unread slot.
import ring_pkg::*;

module ring_slot_bank #(
    parameter int DEPTH = RING_DEPTH,
    parameter int WIDTH = RING_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en_i,
    input  logic [RING_PTR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  phase_e                wr_phase_i,
    input  logic                  ld_en_i,
    input  logic [RING_PTR_W-1:0] ld_addr_i,
    output logic                  sel_vld_o,
    output logic [WIDTH-1:0]      sel_data_o,
    output phase_e                sel_phase_o,
    output logic                  ovr_evt_o
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [WIDTH-1:0] data_q  [DEPTH];
    phase_e           phase_q [DEPTH];

    // Load clears the consumed slot; a write on the same edge re-arms it.
    always_comb begin
        vld_d = vld_q;
        if (ld_en_i) begin
            vld_d[ld_addr_i] = 1'b0;
        end
        if (wr_en_i) begin
            vld_d[wr_addr_i] = 1'b1;
        end
    end

    // Valid bits are the only slot state that needs a defined reset value.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Word and phase storage, written unconditionally on the writer strobe.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            data_q[wr_addr_i]  <= wr_data_i;
            phase_q[wr_addr_i] <= wr_phase_i;
        end
    end

    // A slot being drained on this edge hands its old word to the reader, so
    // overwriting it then loses nothing.
    assign ovr_evt_o   = wr_en_i && vld_q[wr_addr_i] &&
                         !(ld_en_i && (ld_addr_i == wr_addr_i));
    assign sel_vld_o   = vld_q[ld_addr_i];
    assign sel_data_o  = data_q[ld_addr_i];
    assign sel_phase_o = phase_q[ld_addr_i];

endmodule

// File: rtl/ring_reader.sv
// Read side of the 4-entry round-robin word store: drains slots strictly in
// pointer order over a valid/ready stream and flags overwritten slots.
// Optional feature macro: RING_READER_OVERRUN_CNT_EN enables the saturating
// overrun event counter; without it overrun_cnt is tied to zero.
import ring_pkg::*;

module ring_reader #(
    parameter int DEPTH = RING_DEPTH,
    parameter int WIDTH = RING_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [RING_PTR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [7:0]            wr_cnt,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [WIDTH-1:0]      rd_data,
    output logic [1:0]            rd_phase,
    output logic [RING_PTR_W-1:0] rd_addr,
    output logic                  overrun,
    input  logic                  clr,
    output logic [7:0]            overrun_cnt
);

    rd_state_e             state_q, state_d;
    logic [RING_PTR_W-1:0] rptr_q, rptr_d;
    logic                  load;
    logic                  slot_vld;
    logic [WIDTH-1:0]      slot_data;
    phase_e                slot_phase;
    logic                  ovr_evt;
    logic [WIDTH-1:0]      data_q;
    phase_e                phase_q;
    logic [RING_PTR_W-1:0] addr_q;
    logic                  overrun_q;

    ring_slot_bank #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_bank (
        .clk         (clk),
        .reset       (reset),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .wr_phase_i  (classify_phase(wr_cnt)),
        .ld_en_i     (load),
        .ld_addr_i   (rptr_q),
        .sel_vld_o   (slot_vld),
        .sel_data_o  (slot_data),
        .sel_phase_o (slot_phase),
        .ovr_evt_o   (ovr_evt)
    );

    // Next-state logic: load the slot under rptr whenever the output register
    // is free or being emptied this cycle.
    always_comb begin
        state_d = state_q;
        rptr_d  = rptr_q;
        load    = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (slot_vld) begin
                    load    = 1'b1;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (rd_ready) begin
                    if (slot_vld) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            default: state_d = ST_WAIT;
        endcase
        if (load) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    // State and read pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_WAIT;
            rptr_q  <= '0;
        end else begin
            state_q <= state_d;
            rptr_q  <= rptr_d;
        end
    end

    // Output word register; holds its contents until the next load.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            phase_q <= PASS;
            addr_q  <= '0;
        end else if (load) begin
            data_q  <= slot_data;
            phase_q <= slot_phase;
            addr_q  <= rptr_q;
        end
    end

    // Sticky overrun flag; a same-cycle event outranks clr.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (ovr_evt) begin
            overrun_q <= 1'b1;
        end else if (clr) begin
            overrun_q <= 1'b0;
        end
    end

`ifdef RING_READER_OVERRUN_CNT_EN
    logic [7:0] ocnt_q;

    // Saturating event counter; clr with a simultaneous event restarts at one.
    always_ff @(posedge clk) begin
        if (reset) begin
            ocnt_q <= 8'd0;
        end else if (ovr_evt && clr) begin
            ocnt_q <= 8'd1;
        end else if (clr) begin
            ocnt_q <= 8'd0;
        end else if (ovr_evt && (ocnt_q != 8'hFF)) begin
            ocnt_q <= ocnt_q + 8'd1;
        end
    end

    assign overrun_cnt = ocnt_q;
`else
    assign overrun_cnt = 8'd0;
`endif

    assign rd_valid = (state_q == ST_PRESENT);
    assign rd_data  = data_q;
    assign rd_phase = phase_q;
    assign rd_addr  = addr_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_ring_reader.sv
// Self-checking bench for ring_reader: directed scenarios with literal
// expectations plus randomized traffic against a cycle-level behavioural model.
module tb_ring_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  wr_cnt;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic [1:0]  rd_phase;
    logic [1:0]  rd_addr;
    logic        overrun;
    logic        clr;
    logic [7:0]  overrun_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ring_reader dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_cnt      (wr_cnt),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .rd_phase    (rd_phase),
        .rd_addr     (rd_addr),
        .overrun     (overrun),
        .clr         (clr),
        .overrun_cnt (overrun_cnt)
    );

    // Behavioural model: slot contents as arrays, reader as "word in hand".
    bit          m_vld [4];
    logic [31:0] m_sd  [4];
    logic [1:0]  m_sp  [4];
    int          m_rptr;
    bit          m_valid;
    logic [31:0] m_data;
    logic [1:0]  m_phase;
    logic [1:0]  m_addr;
    bit          m_ovr;
    int          m_ocnt;

    function automatic logic [1:0] phase_of(input int c);
        if (c == 0)         return 2'd0;
        else if (c < 128)   return 2'd1;
        else if (c < 192)   return 2'd2;
        else                return 2'd3;
    endfunction

    function automatic int exp_cnt();
`ifdef RING_READER_OVERRUN_CNT_EN
        return m_ocnt;
`else
        return 0;
`endif
    endfunction

    function automatic int lit_cnt(input int v);
`ifdef RING_READER_OVERRUN_CNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit take;
        bit evt;
        int la;
        if (reset) begin
            for (int i = 0; i < 4; i++) m_vld[i] = 1'b0;
            m_rptr = 0; m_valid = 1'b0; m_data = '0; m_phase = '0; m_addr = '0;
            m_ovr = 1'b0; m_ocnt = 0;
        end else begin
            take = m_vld[m_rptr] && (!m_valid || rd_ready);
            if (m_valid && rd_ready && !take) m_valid = 1'b0;
            la  = m_rptr;
            evt = wr_en && m_vld[wr_addr] && !(take && (la == int'(wr_addr)));
            if (take) begin
                m_data  = m_sd[la];
                m_phase = m_sp[la];
                m_addr  = la[1:0];
                m_valid = 1'b1;
                m_vld[la] = 1'b0;
                m_rptr = (m_rptr + 1) % 4;
            end
            if (wr_en) begin
                m_vld[wr_addr] = 1'b1;
                m_sd[wr_addr]  = wr_data;
                m_sp[wr_addr]  = phase_of(int'(wr_cnt));
            end
            if (evt) begin
                m_ovr  = 1'b1;
                m_ocnt = clr ? 1 : ((m_ocnt < 255) ? m_ocnt + 1 : 255);
            end else if (clr) begin
                m_ovr  = 1'b0;
                m_ocnt = 0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("rd_valid", 32'(rd_valid), 32'(m_valid));
            if (m_valid) begin
                check("rd_data", rd_data, m_data);
                check("rd_phase", 32'(rd_phase), 32'(m_phase));
                check("rd_addr", 32'(rd_addr), 32'(m_addr));
            end
            check("overrun", 32'(overrun), 32'(m_ovr));
            check("overrun_cnt", 32'(overrun_cnt), 32'(exp_cnt()));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [7:0] c);
        wr_en   = 1'b1;
        wr_addr = a[1:0];
        wr_data = d;
        wr_cnt  = c;
    endtask

    task automatic do_reset();
        reset = 1'b1; wr_en = 1'b0; clr = 1'b0;
        step();
        reset = 1'b0;
    endtask

    logic [7:0] cnt_tab [4];
    logic [7:0] edge_tab [8];

    initial begin
        int beats;
        bit found;
        logic [31:0] last;

        cnt_tab[0] = 8'h10; cnt_tab[1] = 8'h90; cnt_tab[2] = 8'hC5; cnt_tab[3] = 8'h00;
        edge_tab[0] = 8'h00; edge_tab[1] = 8'h01; edge_tab[2] = 8'h7F; edge_tab[3] = 8'h80;
        edge_tab[4] = 8'hBF; edge_tab[5] = 8'hC0; edge_tab[6] = 8'hFF; edge_tab[7] = 8'h40;

        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_cnt = '0;
        rd_ready = 1'b0; clr = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;

        // Reset state
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_rd_phase", 32'(rd_phase), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_overrun_cnt", 32'(overrun_cnt), 32'd0);

        // Single word latency, then hold under backpressure
        wr(0, 32'h12345678, 8'h00);
        step();
        wr_en = 1'b0;
        check("lat_not_yet", 32'(rd_valid), 32'd0);
        step();
        check("lat_valid", 32'(rd_valid), 32'd1);
        check("lat_data", rd_data, 32'h12345678);
        check("lat_phase", 32'(rd_phase), 32'd0);
        check("lat_addr", 32'(rd_addr), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_valid", 32'(rd_valid), 32'd1);
            check("hold_data", rd_data, 32'h12345678);
            check("hold_addr", 32'(rd_addr), 32'd0);
        end
        rd_ready = 1'b1;
        step();
        check("hold_done", 32'(rd_valid), 32'd0);

        // Prefilled burst drains back-to-back in address order
        rd_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr(i, 32'h100 + i, cnt_tab[i]);
            step();
        end
        wr_en = 1'b0;
        rd_ready = 1'b1;
        check("burst_addr0", 32'(rd_addr), 32'd0);
        check("burst_phase0", 32'(rd_phase), 32'd1);
        for (int i = 1; i < 4; i++) begin
            step();
            check("burst_valid", 32'(rd_valid), 32'd1);
            check("burst_addr", 32'(rd_addr), 32'(i));
            check("burst_phase", 32'(rd_phase), 32'(phase_of(int'(cnt_tab[i]))));
        end
        step();
        check("burst_end", 32'(rd_valid), 32'd0);

        // Overwrite of an unread slot
        rd_ready = 1'b0;
        wr(1, 32'hA, 8'h05); step();
        wr(1, 32'hB, 8'h05); step();
        wr_en = 1'b0;
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_cnt", 32'(overrun_cnt), 32'(lit_cnt(1)));
        wr(0, 32'hC, 8'h00); step();
        wr_en = 1'b0;
        rd_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (rd_valid && rd_addr == 2'd1) begin
                check("ovr_slot1_data", rd_data, 32'hB);
                found = 1'b1;
            end
            step();
        end
        check("ovr_slot1_seen", 32'(found), 32'd1);

        // Reset while a word is presented and two are pending
        rd_ready = 1'b0;
        wr(2, 32'h22, 8'h01); step();
        wr(3, 32'h33, 8'h01); step();
        wr(0, 32'h44, 8'h01); step();
        wr_en = 1'b0;
        step();
        check("pend_valid", 32'(rd_valid), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_valid", 32'(rd_valid), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        wr(0, 32'h55, 8'h00);
        rd_ready = 1'b1;
        step();
        wr_en = 1'b0;
        beats = 0;
        last = '0;
        for (int i = 0; i < 8; i++) begin
            if (rd_valid) begin
                beats++;
                last = rd_data;
            end
            step();
        end
        check("midrst_beats", 32'(beats), 32'd1);
        check("midrst_word", last, 32'h55);

        // clr colliding with an overrun event
        rd_ready = 1'b0;
        wr(3, 32'h1, 8'h00); step();
        wr(3, 32'h2, 8'h00); step();
        check("clr_pre_cnt", 32'(overrun_cnt), 32'(lit_cnt(1)));
        wr(3, 32'h3, 8'h00); clr = 1'b1; step();
        wr_en = 1'b0;
        check("clr_evt_flag", 32'(overrun), 32'd1);
        check("clr_evt_cnt", 32'(overrun_cnt), 32'(lit_cnt(1)));
        step();
        clr = 1'b0;
        check("clr_only_flag", 32'(overrun), 32'd0);
        check("clr_only_cnt", 32'(overrun_cnt), 32'd0);

        // Counter saturation
        do_reset();
        wr(0, 32'h9, 8'h00); step();
        for (int i = 0; i < 270; i++) begin
            wr(1, $urandom, 8'(($urandom % 256))); step();
        end
        wr_en = 1'b0;
        check("sat_cnt", 32'(overrun_cnt), 32'(lit_cnt(255)));
        check("sat_flag", 32'(overrun), 32'd1);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            wr_en    = ($urandom % 2) == 0;
            wr_addr  = 2'($urandom % 4);
            wr_data  = $urandom;
            wr_cnt   = (($urandom % 3) == 0) ? edge_tab[$urandom % 8] : 8'($urandom % 256);
            rd_ready = ($urandom % 4) != 0;
            clr      = ($urandom % 16) == 0;
            reset    = ($urandom % 150) == 0;
            step();
        end
        reset = 1'b0; wr_en = 1'b0; clr = 1'b0; rd_ready = 1'b1;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
